sequential_left_shift: RTL and testbench

//   Multi-cycle ALU left shifter. One bit per clock, logical or rotate, with

---
 rtl/sequential_left_shift.sv | 102 ++++++++++
 tb/tb_sequential_left_shift.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sequential_left_shift.sv
// Multi-cycle left shifter for the ALU: shifts one bit per clock toward the
// MSB, either logical (zero fill) or rotate, with start/busy/done handshake
// and registered carry/zero status flags.
module sequential_left_shift #(
  parameter int WIDTH = 8,
  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    amt,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   count;
  logic            mode_r;
  logic [WIDTH-1:0] shift_nxt;

  // One-bit left step; rotate wraps the MSB into bit 0, logical fills zero.
  function automatic logic [WIDTH-1:0] shl_step(input logic [WIDTH-1:0] val,
                                                input logic             rot);
    shl_step = {val[WIDTH-2:0], (rot ? val[WIDTH-1] : 1'b0)};
  endfunction

  // Zero flag is derived from the value about to be written into out.
  function automatic logic is_zero(input logic [WIDTH-1:0] val);
    is_zero = (val == '0);
  endfunction

  // Next value of out while shifting, using the mode captured at start.
  always_comb begin
    shift_nxt = shl_step(out, mode_r);
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE so ops can run back to back.
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            out    <= in;
            carry  <= 1'b0;
            zero   <= is_zero(in);
            mode_r <= mode;
            if (amt != '0) begin
              count <= amt;
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          out   <= shift_nxt;
          carry <= out[WIDTH-1];
          zero  <= is_zero(shift_nxt);
          count <= count - 1'b1;
          if (count == AW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_left_shift.sv
// Directed testbench for sequential_left_shift (WIDTH=8).
module tb_sequential_left_shift;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_v;
  logic [2:0] amt;
  logic       mode;
  logic [7:0] out;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int lat;
  int bcnt;
  int both_high = 0;

  sequential_left_shift #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in_v),
    .amt   (amt),
    .mode  (mode),
    .out   (out),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) both_high++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start, then wait (bounded) for done; lat = edges after accept.
  task automatic run_op(input logic [7:0] a, input logic [2:0] n, input logic m,
                        output int l, output int b);
    @(negedge clk);
    start = 1'b1; in_v = a; amt = n; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0; b = 0;
    while (!done && l < 50) begin
      if (busy) b++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  // Wait (bounded) for done from the current point, counting edges.
  task automatic wait_done(output int l);
    l = 0;
    while (!done && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_v = '0; amt = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   out,   8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero",  zero,  1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    @(negedge clk); rst = 1'b0;

    // 1: logical, amt=1
    run_op(8'b11001010, 3'd1, 1'b0, lat, bcnt);
    chk("t1_lat",   lat,   1);
    chk("t1_busy",  bcnt,  1);
    chk("t1_out",   out,   8'b10010100);
    chk("t1_carry", carry, 1'b1);
    chk("t1_zero",  zero,  1'b0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_hold_out",   out,  8'b10010100);

    // 2: amt=3 logical and rotate
    run_op(8'b11001010, 3'd3, 1'b0, lat, bcnt);
    chk("t2l_lat",   lat,   3);
    chk("t2l_out",   out,   8'b01010000);
    chk("t2l_carry", carry, 1'b0);
    run_op(8'b11001010, 3'd3, 1'b1, lat, bcnt);
    chk("t2r_lat",   lat,   3);
    chk("t2r_out",   out,   8'b01010110);
    chk("t2r_carry", carry, 1'b0);

    // 3: amt=0, both modes
    run_op(8'b00001111, 3'd0, 1'b0, lat, bcnt);
    chk("t3l_lat",   lat,   0);
    chk("t3l_busy",  bcnt,  0);
    chk("t3l_out",   out,   8'b00001111);
    chk("t3l_carry", carry, 1'b0);
    run_op(8'b00001111, 3'd0, 1'b1, lat, bcnt);
    chk("t3r_lat",   lat,   0);
    chk("t3r_busy",  bcnt,  0);
    chk("t3r_out",   out,   8'b00001111);

    // 4: zero flag and full-width shift
    run_op(8'b10000000, 3'd1, 1'b0, lat, bcnt);
    chk("t4a_out",   out,   8'h00);
    chk("t4a_carry", carry, 1'b1);
    chk("t4a_zero",  zero,  1'b1);
    run_op(8'b00000001, 3'd7, 1'b0, lat, bcnt);
    chk("t4b_lat",   lat,   7);
    chk("t4b_out",   out,   8'b10000000);
    chk("t4b_carry", carry, 1'b0);
    chk("t4b_zero",  zero,  1'b0);

    // 5: start while busy is ignored; start held in DONE accepted
    @(negedge clk);
    start = 1'b1; in_v = 8'b11001010; amt = 3'd5; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; in_v = 8'hFF; amt = 3'd1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_v = 8'h00; amt = 3'd0; mode = 1'b0;
    wait_done(lat);
    chk("t5_lat",   lat,   3);
    chk("t5_out",   out,   8'b01000000);
    chk("t5_carry", carry, 1'b1);
    start = 1'b1; in_v = 8'b00001111; amt = 3'd2; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_b2b_busy", busy, 1'b1);
    chk("t5_b2b_done", done, 1'b0);
    chk("t5_b2b_load", out,  8'b00001111);
    wait_done(lat);
    chk("t5_b2b_lat",   lat,   2);
    chk("t5_b2b_out",   out,   8'b00111100);
    chk("t5_b2b_carry", carry, 1'b0);

    // 6: reset aborts a shift in progress
    @(negedge clk);
    start = 1'b1; in_v = 8'b11001010; amt = 3'd6; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_out",   out,   8'h00);
    chk("t6_carry", carry, 1'b0);
    chk("t6_zero",  zero,  1'b0);
    chk("t6_busy",  busy,  1'b0);
    chk("t6_done",  done,  1'b0);
    @(negedge clk); rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) bcnt++;
    end
    chk("t6_no_done", bcnt, 0);
    run_op(8'b00000011, 3'd2, 1'b1, lat, bcnt);
    chk("t6_lat",   lat,   2);
    chk("t6_out",   out,   8'b00001100);
    chk("t6_carry", carry, 1'b0);

    chk("busy_done_excl", both_high, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
